// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline sequencing controller for stalls, flushes,
// multi-cycle memory waits and halt.
// All hold/bubble/flush outputs are combinational from the registered state
// and the current inputs.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cycles and
// flush_events saturating counters and the perf_clr input.
module pipe_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        resume,
`ifdef PIPE_PERF_CNT_EN
    input  logic        perf_clr,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
`endif
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_SHADOW  = 3'd1,
        S_MEMWAIT = 3'd2,
        S_DRAIN   = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register; reset forces RUN immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; unused encodings fall back to RUN.
    always_comb begin
        state_nxt   = S_RUN;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        case (state)
            S_RUN: begin
                if (halt_req) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = S_HALT;
                end else if (mem_busy) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    state_nxt = S_MEMWAIT;
                end else if (branch_taken) begin
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    state_nxt   = S_SHADOW;
                end else if (jump_id) begin
                    flush_ifid = 1'b1;
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            // Squashed-path cycle: only halt and memory wait are honoured.
            S_SHADOW: begin
                if (halt_req) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = S_HALT;
                end else if (mem_busy) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    state_nxt = S_MEMWAIT;
                end
            end
            S_MEMWAIT: begin
                if (mem_busy) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    state_nxt = S_MEMWAIT;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                idex_bubble = 1'b1;
                if (load_use) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                end
            end
            S_HALT: begin
                if (!resume) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = S_HALT;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign state_o = state;

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters; perf_clr takes precedence over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_hold && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush_idex && (flush_events != '1)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: the driver queues the expected
// {state_o, pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex,
// flush_exmem} vector for every cycle it drives; the monitor pops and
// compares on the falling edge.
module tb_pipe_seq_ctrl;

    logic clk;
    logic rst_n;
    logic load_use, branch_taken, jump_id, mem_busy, halt_req, resume;
    logic pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem;
    logic [2:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic perf_clr;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sbq[$];

    pipe_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .jump_id      (jump_id),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .resume       (resume),
`ifdef PIPE_PERF_CNT_EN
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
`endif
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_exmem  (flush_exmem),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: one comparison per queued expectation, mid-cycle.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = {state_o, pc_hold, ifid_hold, idex_bubble,
                       flush_ifid, flush_idex, flush_exmem};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got st=%0d out=%b, expected st=%0d out=%b",
                             e.name, act[8:6], act[5:0], e.exp[8:6], e.exp[5:0]);
                end
            end
        end
    end

    // Drive one cycle of inputs (just after the rising edge) and queue the
    // expected outputs for that cycle.
    task automatic step(input string nm, input logic lu, input logic bt,
                        input logic jid, input logic mb, input logic hr,
                        input logic rs, input logic [8:0] exp);
        load_use     = lu;
        branch_taken = bt;
        jump_id      = jid;
        mem_busy     = mb;
        halt_req     = hr;
        resume       = rs;
        sbq.push_back('{nm, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        load_use = 0; branch_taken = 0; jump_id = 0;
        mem_busy = 0; halt_req = 0; resume = 0;
`ifdef PIPE_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        //            name           lu bt jd mb hr rs  st  ph ih ib fi fx fm
        step("reset_state",          0, 0, 0, 0, 0, 0, 9'b000_000000);
        rst_n = 1'b1;
        step("idle",                 0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Load-use stall for exactly one cycle.
        step("load_use",             1, 0, 0, 0, 0, 0, 9'b000_111000);
        step("load_use_after",       0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Branch beats load_use; load_use masked in SHADOW.
        step("branch_lu",            1, 1, 0, 0, 0, 0, 9'b000_000111);
        step("shadow_lu_masked",     1, 0, 0, 0, 0, 0, 9'b001_000000);
        step("shadow_exit",          0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Jump flushes IF/ID only and outranks load_use.
        step("jump",                 0, 0, 1, 0, 0, 0, 9'b000_000100);
        step("jump_lu",              1, 0, 1, 0, 0, 0, 9'b000_000100);
        step("jump_after",           0, 0, 0, 0, 0, 0, 9'b000_000000);

        // mem_busy 3 cycles; branch/load_use ignored in MEMWAIT.
        step("mem_busy_run",         0, 0, 0, 1, 0, 0, 9'b000_110000);
        step("memwait_1",            0, 0, 0, 1, 0, 0, 9'b010_110000);
        step("memwait_ignore_bt_lu", 1, 1, 0, 1, 0, 0, 9'b010_110000);
        step("memwait_release",      0, 0, 0, 0, 0, 0, 9'b010_000000);
        step("drain",                0, 0, 0, 0, 0, 0, 9'b011_001000);
        step("drain_after",          0, 0, 0, 0, 0, 0, 9'b000_000000);

        // DRAIN with load_use also holds.
        step("mem_busy_run2",        0, 0, 0, 1, 0, 0, 9'b000_110000);
        step("memwait_release2",     0, 0, 0, 0, 0, 0, 9'b010_000000);
        step("drain_lu",             1, 0, 0, 0, 0, 0, 9'b011_111000);
        step("drain_lu_after",       0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Halt beats branch; hold persists until resume.
        step("halt_branch",          0, 1, 0, 0, 1, 0, 9'b000_111000);
        for (int i = 0; i < 10; i++) begin
            step("halt_hold", i[0], i[1], 0, 0, 0, 0, 9'b100_111000);
        end
        step("halt_resume",          0, 0, 0, 0, 0, 1, 9'b100_000000);
        step("resume_after",         0, 0, 0, 0, 0, 0, 9'b000_000000);

        // SHADOW honours mem_busy.
        step("branch",               0, 1, 0, 0, 0, 0, 9'b000_000111);
        step("shadow_mem_busy",      0, 0, 0, 1, 0, 0, 9'b001_110000);
        step("shadow_memwait_rel",   0, 0, 0, 0, 0, 0, 9'b010_000000);
        step("shadow_drain",         0, 0, 0, 0, 0, 0, 9'b011_001000);
        step("shadow_drain_after",   0, 0, 0, 0, 0, 0, 9'b000_000000);

        // SHADOW honours halt_req; branch in SHADOW ignored.
        step("branch2",              0, 1, 0, 0, 0, 0, 9'b000_000111);
        step("shadow_halt",          0, 1, 0, 0, 1, 0, 9'b001_111000);
        step("shadow_halt_hold",     0, 0, 0, 0, 0, 0, 9'b100_111000);
        step("shadow_halt_resume",   0, 0, 0, 0, 0, 1, 9'b100_000000);
        step("shadow_halt_after",    0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Priority: halt over mem_busy, mem_busy over branch.
        step("halt_over_mem",        0, 0, 0, 1, 1, 0, 9'b000_111000);
        step("halt_over_mem_st",     0, 0, 0, 0, 0, 1, 9'b100_000000);
        step("mem_over_branch",      0, 1, 0, 1, 0, 0, 9'b000_110000);
        step("mem_over_branch_st",   0, 0, 0, 0, 0, 0, 9'b010_000000);
        step("mem_over_branch_dr",   0, 0, 0, 0, 0, 0, 9'b011_001000);
        step("mem_over_branch_end",  0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Asynchronous reset mid-MEMWAIT, checked before the next edge.
        step("pre_rst_mem",          0, 0, 0, 1, 0, 0, 9'b000_110000);
        step("pre_rst_memwait",      0, 0, 0, 1, 0, 0, 9'b010_110000);
        rst_n = 1'b0;
        step("rst_in_memwait",       0, 0, 0, 0, 0, 0, 9'b000_000000);
        rst_n = 1'b1;
        step("post_rst_mem",         0, 0, 0, 0, 0, 0, 9'b000_000000);

        // Asynchronous reset mid-HALT.
        step("pre_rst_halt",         0, 0, 0, 0, 1, 0, 9'b000_111000);
        step("pre_rst_halted",       0, 0, 0, 0, 0, 0, 9'b100_111000);
        rst_n = 1'b0;
        step("rst_in_halt",          0, 0, 0, 0, 0, 0, 9'b000_000000);
        rst_n = 1'b1;
        step("post_rst_halt",        0, 0, 0, 0, 0, 0, 9'b000_000000);

`ifdef PIPE_PERF_CNT_EN
        // Long load_use stall saturates the stall counter; clear wins.
        @(negedge clk);
        load_use = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_sat: got %h, expected ffff", stall_cycles);
        end
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        load_use = 1'b0;
        checks++;
        if (stall_cycles !== 16'h0000) begin
            errors++;
            $display("FAIL stall_clr: got %h, expected 0000", stall_cycles);
        end
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
